// File: rtl/order_server_queue_if.sv
// Order/serve handshake bundle between the order generator, the serving
// station and the order server.
interface order_server_queue_if #(
    parameter int ING_W = 12
);
    logic [ING_W-1:0] order_in;
    logic             order_valid;
    logic             order_ready;
    logic [ING_W-1:0] plate;
    logic             serve;
    logic [ING_W-1:0] plate_out;
    logic             serve_ack;
    logic             serve_hit;

    modport master (
        output order_in, order_valid, plate, serve,
        input  order_ready, plate_out, serve_ack, serve_hit
    );

    modport slave (
        input  order_in, order_valid, plate, serve,
        output order_ready, plate_out, serve_ack, serve_hit
    );
endinterface

// File: rtl/order_server_queue.sv
// Order server: N_ORDERS recipe slots with countdown timers, plate matching
// on serve, and saturating done/missed counters. Runs on the 10 Hz game tick.
module order_server_queue #(
    parameter int N_ORDERS = 3,
    parameter int ING_W    = 12,
    parameter int TIMEOUT  = 600,
    parameter int CNT_W    = 8,
    parameter int EXACT    = 0
) (
    input  logic                  clk_10Hz,
    input  logic                  reset,
    order_server_queue_if.slave   bus,
    output logic [N_ORDERS-1:0]   slot_busy,
    output logic [N_ORDERS-1:0]   slot_urgent,
    output logic                  expired,
    output logic [CNT_W-1:0]      orders_done,
    output logic [CNT_W-1:0]      orders_missed
);

    localparam logic [9:0] TIMEOUT_T = 10'(TIMEOUT);
    localparam logic [9:0] URGENT_T  = 10'(TIMEOUT / 4);

    typedef enum logic {FREE = 1'b0, ACTIVE = 1'b1} slot_state_e;

    slot_state_e      state_q  [N_ORDERS];
    slot_state_e      state_d  [N_ORDERS];
    logic [ING_W-1:0] recipe_q [N_ORDERS];
    logic [ING_W-1:0] recipe_d [N_ORDERS];
    logic [9:0]       timer_q  [N_ORDERS];
    logic [9:0]       timer_d  [N_ORDERS];

    logic [N_ORDERS-1:0] busy;
    logic [N_ORDERS-1:0] urgent_q, urgent_d;
    logic [N_ORDERS-1:0] load_sel, match_sel;
    logic                load_en, any_match;
    logic [ING_W-1:0]    win_recipe;
    logic [3:0]          n_exp;

    logic [ING_W-1:0] plate_out_q, plate_out_d;
    logic             ack_q, ack_d;
    logic             hit_q, hit_d;
    logic             expired_q, expired_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic [CNT_W-1:0] missed_q, missed_d;

    function automatic logic recipe_matches(input logic [ING_W-1:0] plate,
                                            input logic [ING_W-1:0] recipe);
        if (EXACT != 0) return plate == recipe;
        else            return (plate & recipe) == recipe;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [3:0]       inc);
        logic [CNT_W+3:0] sum;
        sum = (CNT_W+4)'(cnt) + (CNT_W+4)'(inc);
        if (sum > (CNT_W+4)'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
        else                                  return sum[CNT_W-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N_ORDERS; i++) busy[i] = (state_q[i] == ACTIVE);
    end

    assign bus.order_ready = ~&busy;

    // Priority picks: lowest FREE slot for a load, lowest ACTIVE match for a serve.
    always_comb begin
        logic found_l, found_m;
        load_sel   = '0;
        match_sel  = '0;
        win_recipe = '0;
        found_l    = 1'b0;
        found_m    = 1'b0;
        for (int i = 0; i < N_ORDERS; i++) begin
            if (!busy[i] && !found_l) begin
                load_sel[i] = 1'b1;
                found_l     = 1'b1;
            end
            if (busy[i] && !found_m && recipe_matches(bus.plate, recipe_q[i])) begin
                match_sel[i] = 1'b1;
                found_m      = 1'b1;
                win_recipe   = recipe_q[i];
            end
        end
        any_match = bus.serve && found_m;
        load_en   = bus.order_valid && found_l && (bus.order_in != '0);
    end

    always_comb begin
        plate_out_d = plate_out_q;
        ack_d       = 1'b0;
        hit_d       = 1'b0;
        n_exp       = 4'd0;
        for (int i = 0; i < N_ORDERS; i++) begin
            state_d[i]  = state_q[i];
            recipe_d[i] = recipe_q[i];
            timer_d[i]  = timer_q[i];
        end
        urgent_d = '0;

        if (bus.serve) begin
            ack_d       = 1'b1;
            hit_d       = any_match;
            plate_out_d = any_match ? (bus.plate & ~win_recipe) : bus.plate;
        end

        for (int i = 0; i < N_ORDERS; i++) begin
            if (state_q[i] == ACTIVE) begin
                timer_d[i] = timer_q[i] - 10'd1;
                // A serve on the final tick beats the expiry.
                if (bus.serve && match_sel[i]) begin
                    state_d[i] = FREE;
                end else if (timer_q[i] == 10'd1) begin
                    state_d[i] = FREE;
                    n_exp      = n_exp + 4'd1;
                end
            end else if (load_en && load_sel[i]) begin
                state_d[i]  = ACTIVE;
                recipe_d[i] = bus.order_in;
                timer_d[i]  = TIMEOUT_T;
            end
            urgent_d[i] = (state_d[i] == ACTIVE) && (timer_d[i] <= URGENT_T);
        end

        expired_d = (n_exp != 4'd0);
        missed_d  = sat_add(missed_q, n_exp);
        done_d    = sat_add(done_q, {3'd0, any_match});
    end

    always_ff @(posedge clk_10Hz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ORDERS; i++) state_q[i] <= FREE;
            urgent_q    <= '0;
            plate_out_q <= '0;
            ack_q       <= 1'b0;
            hit_q       <= 1'b0;
            expired_q   <= 1'b0;
            done_q      <= '0;
            missed_q    <= '0;
        end else begin
            for (int i = 0; i < N_ORDERS; i++) state_q[i] <= state_d[i];
            urgent_q    <= urgent_d;
            plate_out_q <= plate_out_d;
            ack_q       <= ack_d;
            hit_q       <= hit_d;
            expired_q   <= expired_d;
            done_q      <= done_d;
            missed_q    <= missed_d;
        end
    end

    // Recipe and timer contents are only meaningful while the slot is ACTIVE.
    always_ff @(posedge clk_10Hz) begin
        for (int i = 0; i < N_ORDERS; i++) begin
            recipe_q[i] <= recipe_d[i];
            timer_q[i]  <= timer_d[i];
        end
    end

    assign slot_busy     = busy;
    assign slot_urgent   = urgent_q;
    assign expired       = expired_q;
    assign orders_done   = done_q;
    assign orders_missed = missed_q;
    assign bus.plate_out = plate_out_q;
    assign bus.serve_ack = ack_q;
    assign bus.serve_hit = hit_q;

endmodule
